plot_shadow: RTL and testbench

Passive listener on the pixel plot bus (x, y, colour, plot) that drives the 320x240 VGA adapter. It keeps a shadow copy of every in-range pixel written and serves pipelined pixel read-back requests, so game logic can read what is on screen (e.g. grid cell occupancy, collision checks) without touching the adapter. It sits in parallel with the VGA adapter on the same bus, downstream of the drawing sequencer.

---
 rtl/plot_pkg.sv | 22 ++
 rtl/shadow_ram.sv | 25 ++
 rtl/plot_shadow.sv | 158 +++++++++++++++
 tb/tb_plot_shadow.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/plot_pkg.sv
// Shared constants, types and address helpers for the plot-bus shadow framebuffer.
package plot_pkg;

    localparam int unsigned SCREEN_W  = 320;
    localparam int unsigned SCREEN_H  = 240;
    localparam int unsigned PIX_COUNT = 76800;
    localparam int unsigned ADDR_W    = 17;

    typedef logic [2:0] colour_t;

    typedef enum logic {StClear, StIdle} state_t;

    // y*320 + x without a multiplier.
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [8:0] px, input logic [7:0] py);
        return {1'b0, py, 8'b0} + {3'b0, py, 6'b0} + {8'b0, px};
    endfunction

    function automatic logic in_range(input logic [8:0] px, input logic [7:0] py);
        return (px < 9'(SCREEN_W)) && (py < 8'(SCREEN_H));
    endfunction

endpackage

// File: rtl/shadow_ram.sv
// Simple dual-port shadow RAM: one write port, one registered read port, no reset.
module shadow_ram
    import plot_pkg::*;
#(
    parameter int unsigned Depth = PIX_COUNT,
    parameter int unsigned AddrW = ADDR_W
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AddrW-1:0] waddr,
    input  colour_t          wdata,
    input  logic [AddrW-1:0] raddr,
    output colour_t          rdata
);

    colour_t mem [Depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/plot_shadow.sv
// Shadow copy of the 320x240 plot bus with a 2-cycle pipelined pixel read-back port.
// Optional post-reset clear sweep enabled by defining PLOT_SHADOW_CLEAR_EN.
module plot_shadow
    import plot_pkg::*;
#(
    parameter colour_t CLEAR_COLOUR = 3'b111
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [8:0]  x,
    input  logic [7:0]  y,
    input  logic [2:0]  colour,
    input  logic        plot,
    input  logic        rd_req,
    input  logic [8:0]  rd_x,
    input  logic [7:0]  rd_y,
    output logic        rd_ready,
    output logic        rd_valid,
    output logic [2:0]  rd_colour,
    output logic        busy,
    output logic [16:0] wr_count
);

    localparam logic [16:0] WrMax = '1;

    state_t state_q, state_d;
    logic   clearing;
    logic [ADDR_W-1:0] clr_addr;

`ifdef PLOT_SHADOW_CLEAR_EN
    logic [ADDR_W-1:0] sweep_q, sweep_d;
`endif

    always_comb begin
        state_d = state_q;
`ifdef PLOT_SHADOW_CLEAR_EN
        sweep_d = sweep_q;
        if (state_q == StClear) begin
            if (sweep_q == ADDR_W'(PIX_COUNT - 1)) begin
                state_d = StIdle;
            end else begin
                sweep_d = sweep_q + 1'b1;
            end
        end
        clr_addr = sweep_q;
`else
        state_d  = StIdle;
        clr_addr = '0;
`endif
    end

    assign clearing = (state_q == StClear);
    assign busy     = clearing;
    assign rd_ready = !clearing;

    // Write side
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    colour_t           ram_wdata;
    colour_t           ram_rdata;

    assign wr_addr   = pix_addr(x, y);
    assign wr_en     = !clearing && plot && in_range(x, y);
    assign ram_we    = clearing || wr_en;
    assign ram_waddr = clearing ? clr_addr : wr_addr;
    assign ram_wdata = clearing ? CLEAR_COLOUR : colour;

    // Read side
    logic              rd_accept;
    logic              rd_ok;
    logic [ADDR_W-1:0] rd_addr;
    logic              bypass;

    assign rd_accept = rd_req && rd_ready;
    assign rd_ok     = in_range(rd_x, rd_y);
    assign rd_addr   = pix_addr(rd_x, rd_y);
    // Same-cycle write to the requested pixel wins over the RAM contents.
    assign bypass    = wr_en && rd_ok && (wr_addr == rd_addr);

    logic              s1_valid_q, s1_in_range_q, s1_bypass_q;
    colour_t           s1_byp_colour_q;
    logic [ADDR_W-1:0] s1_addr_q;
    logic              s2_valid_q, s2_in_range_q, s2_bypass_q;
    colour_t           s2_byp_colour_q;
    logic              rd_valid_q;
    colour_t           rd_colour_q, rd_colour_d;
    logic [16:0]       wr_count_q;

    always_comb begin
        rd_colour_d = '0;
        if (s2_in_range_q) begin
            rd_colour_d = s2_bypass_q ? s2_byp_colour_q : ram_rdata;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
`ifdef PLOT_SHADOW_CLEAR_EN
            state_q <= StClear;
            sweep_q <= '0;
`else
            state_q <= StIdle;
`endif
            s1_valid_q      <= 1'b0;
            s1_in_range_q   <= 1'b0;
            s1_bypass_q     <= 1'b0;
            s1_byp_colour_q <= '0;
            s1_addr_q       <= '0;
            s2_valid_q      <= 1'b0;
            s2_in_range_q   <= 1'b0;
            s2_bypass_q     <= 1'b0;
            s2_byp_colour_q <= '0;
            rd_valid_q      <= 1'b0;
            rd_colour_q     <= '0;
            wr_count_q      <= '0;
        end else begin
            state_q <= state_d;
`ifdef PLOT_SHADOW_CLEAR_EN
            sweep_q <= sweep_d;
`endif
            s1_valid_q      <= rd_accept;
            s1_in_range_q   <= rd_ok;
            s1_bypass_q     <= bypass;
            s1_byp_colour_q <= colour;
            s1_addr_q       <= rd_ok ? rd_addr : '0;
            s2_valid_q      <= s1_valid_q;
            s2_in_range_q   <= s1_in_range_q;
            s2_bypass_q     <= s1_bypass_q;
            s2_byp_colour_q <= s1_byp_colour_q;
            rd_valid_q      <= s2_valid_q;
            if (s2_valid_q) begin
                rd_colour_q <= rd_colour_d;
            end
            if (wr_en && (wr_count_q != WrMax)) begin
                wr_count_q <= wr_count_q + 1'b1;
            end
        end
    end

    shadow_ram #(
        .Depth (PIX_COUNT),
        .AddrW (ADDR_W)
    ) u_ram (
        .clk   (CLOCK_50),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (s1_addr_q),
        .rdata (ram_rdata)
    );

    assign rd_valid  = rd_valid_q;
    assign rd_colour = rd_colour_q;
    assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_plot_shadow.sv
// Directed self-checking bench for plot_shadow; follows PLOT_SHADOW_CLEAR_EN if defined.
module tb_plot_shadow;

    logic        CLOCK_50;
    logic        reset;
    logic [8:0]  x;
    logic [7:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        rd_req;
    logic [8:0]  rd_x;
    logic [7:0]  rd_y;
    logic        rd_ready;
    logic        rd_valid;
    logic [2:0]  rd_colour;
    logic        busy;
    logic [16:0] wr_count;

`ifdef PLOT_SHADOW_CLEAR_EN
    localparam logic CLR = 1'b1;
`else
    localparam logic CLR = 1'b0;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    plot_shadow dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .plot      (plot),
        .rd_req    (rd_req),
        .rd_x      (rd_x),
        .rd_y      (rd_y),
        .rd_ready  (rd_ready),
        .rd_valid  (rd_valid),
        .rd_colour (rd_colour),
        .busy      (busy),
        .wr_count  (wr_count)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int px, input int py, input logic [2:0] c);
        x = 9'(px); y = 8'(py); colour = c; plot = 1'b1;
        tick();
        plot = 1'b0;
    endtask

    // Single read; rd_valid must be low one edge after acceptance and high two edges after.
    task automatic rd(input string tag, input int px, input int py, input logic [2:0] exp);
        rd_x = 9'(px); rd_y = 8'(py); rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
        chk({tag, "_early"}, 32'(rd_valid), 32'd0);
        tick();
        chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
        chk({tag, "_colour"}, 32'(rd_colour), 32'(exp));
    endtask

    initial begin
        logic [2:0] pcol [4];
        int n;
        pcol[0] = 3'b100; pcol[1] = 3'b101; pcol[2] = 3'b110; pcol[3] = 3'b011;

        reset = 1'b1; x = '0; y = '0; colour = '0; plot = 1'b0;
        rd_req = 1'b0; rd_x = '0; rd_y = '0;
        tick(); tick(); tick();

        chk("rst_busy", 32'(busy), 32'(CLR));
        chk("rst_ready", 32'(rd_ready), 32'(!CLR));
        chk("rst_valid", 32'(rd_valid), 32'd0);
        chk("rst_colour", 32'(rd_colour), 32'd0);
        chk("rst_count", 32'(wr_count), 32'd0);

        reset = 1'b0;
`ifdef PLOT_SHADOW_CLEAR_EN
        // Plot during the sweep must be ignored.
        x = 9'd3; y = 8'd3; colour = 3'b010; plot = 1'b1;
        n = 0;
        while (busy && n < 80000) begin
            tick();
            n++;
        end
        plot = 1'b0;
        chk("clear_len", 32'(n), 32'd76800);
        chk("clear_ready", 32'(rd_ready), 32'd1);
        chk("clear_count", 32'(wr_count), 32'd0);
        rd("clr_0_0", 0, 0, 3'b111);
        rd("clr_319_239", 319, 239, 3'b111);
        rd("clr_160_120", 160, 120, 3'b111);
`else
        chk("noclr_busy", 32'(busy), 32'd0);
`endif

        // Write then read
        wr(5, 7, 3'b010);
        rd("wr_5_7", 5, 7, 3'b010);
        chk("wr_count1", 32'(wr_count), 32'd1);

        // Same-cycle write/read bypass
        x = 9'd100; y = 8'd50; colour = 3'b001; plot = 1'b1;
        rd_x = 9'd100; rd_y = 8'd50; rd_req = 1'b1;
        tick();
        plot = 1'b0; rd_req = 1'b0;
        tick();
        chk("byp_early", 32'(rd_valid), 32'd0);
        tick();
        chk("byp_valid", 32'(rd_valid), 32'd1);
        chk("byp_colour", 32'(rd_colour), 32'd1);
        chk("wr_count2", 32'(wr_count), 32'd2);

        // Out-of-range writes and read
        wr(320, 0, 3'b011);
        wr(0, 240, 3'b011);
        chk("oor_count", 32'(wr_count), 32'd2);
        rd("oor_rd", 400, 10, 3'b000);

        // Back-to-back pipelined reads
        for (int i = 0; i < 4; i++) wr(10 + i, 1, pcol[i]);
        chk("pipe_count", 32'(wr_count), 32'd6);
        for (int i = 0; i < 6; i++) begin
            rd_req = (i < 4); rd_x = 9'(10 + i); rd_y = 8'd1;
            tick();
            if (i < 2) begin
                chk("pipe_early", 32'(rd_valid), 32'd0);
            end else begin
                chk("pipe_valid", 32'(rd_valid), 32'd1);
                chk("pipe_colour", 32'(rd_colour), 32'(pcol[i-2]));
            end
            rd_req = 1'b0;
        end
        tick();
        chk("pipe_tail", 32'(rd_valid), 32'd0);

        // Reset with two reads in flight
        wr(20, 2, 3'b001);
        wr(21, 2, 3'b010);
        wr(22, 2, 3'b100);
        chk("pre_rst_count", 32'(wr_count), 32'd9);
        rd_x = 9'd5; rd_y = 8'd7; rd_req = 1'b1;
        tick();
        tick();
        rd_req = 1'b0;
        reset = 1'b1;
        #1;
        chk("mid_rst_count", 32'(wr_count), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'(CLR));
        chk("mid_rst_valid", 32'(rd_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_rst_hold", 32'(rd_valid), 32'd0);
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_valid", 32'(rd_valid), 32'd0);
        end
`ifdef PLOT_SHADOW_CLEAR_EN
        for (int i = 0; i < 100; i++) tick();
        chk("resweep_busy", 32'(busy), 32'd1);
        chk("resweep_ready", 32'(rd_ready), 32'd0);
        chk("resweep_count", 32'(wr_count), 32'd0);
`else
        rd("post_rst_rd", 5, 7, 3'b010);
        chk("post_rst_count", 32'(wr_count), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
